// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU operand sequencer: FSM states, command byte
// layout and ALU operation selects.
package alu_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GET_A = 2'd1;
  localparam logic [1:0] ST_GET_B = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  localparam int CMD_ACC_A    = 3;
  localparam int CMD_UNARY    = 4;
  localparam int CMD_RSVD_MSB = 7;
  localparam int CMD_RSVD_LSB = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_ADD2 = 3'd7
  } alu_sel_e;

  function automatic logic cmd_rsvd_err(input logic [7:0] cmd);
    return |cmd[CMD_RSVD_MSB:CMD_RSVD_LSB];
  endfunction

endpackage

// File: rtl/alu_seq_timeout.sv
// Idle-cycle counter for operand collection; expire fires on the LIMIT-th
// consecutive enabled cycle so the caller can abort on that same edge.
module alu_seq_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = en & ~clr & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects command/operand bytes from a byte stream and issues them to the
// combinational ALU, capturing the result into a reusable accumulator.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [OPW-1:0]   sel_out,
  output logic             issue_valid,
  input  logic             issue_ready,
  input  logic [WIDTH-1:0] res_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] acc_out,
  output logic             acc_carry,
  output logic             busy,
  output logic             err,
  output logic [7:0]       ops_count
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [OPW-1:0]   sel_q, sel_d;
  logic             unary_q, unary_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [7:0]       ops_q, ops_d;
  logic             collecting, to_expire;

  assign collecting = (state_q == ST_GET_A) || (state_q == ST_GET_B);

  // GET_A/GET_B always accept, so any in_valid there is a consumed byte.
  alu_seq_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (~collecting | in_valid),
    .en     (collecting & ~in_valid),
    .expire (to_expire)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    unary_d = unary_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ops_d   = ops_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (cmd_rsvd_err(in_data)) begin
            err_d = 1'b1;
          end else begin
            sel_d   = in_data[OPW-1:0];
            unary_d = in_data[CMD_UNARY];
            if (in_data[CMD_ACC_A]) begin
              a_d = acc_q;
              if (in_data[CMD_UNARY]) begin
                b_d     = '0;
                state_d = ST_ISSUE;
              end else begin
                state_d = ST_GET_B;
              end
            end else begin
              state_d = ST_GET_A;
            end
          end
        end
      end
      ST_GET_A: begin
        if (in_valid) begin
          a_d = WIDTH'(in_data);
          if (unary_q) begin
            b_d     = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_GET_B;
          end
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_GET_B: begin
        if (in_valid) begin
          b_d     = WIDTH'(in_data);
          state_d = ST_ISSUE;
        end else if (to_expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Operands stay frozen until the ALU stage takes them.
        if (issue_ready) begin
          acc_d   = res_in;
          carry_d = carry_in;
          ops_d   = ops_q + 8'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      unary_q <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ops_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      unary_q <= unary_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ops_q   <= ops_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q != ST_ISSUE);
  assign issue_valid = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE);
  assign a_out       = a_q;
  assign b_out       = b_q;
  assign sel_out     = sel_q;
  assign acc_out     = acc_q;
  assign acc_carry   = carry_q;
  assign ops_count   = ops_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed vector table, hand-written corner
// sequences and randomized traffic against a frame-level reference model.
module tb_alu_operand_sequencer;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_out, b_out;
  logic [2:0] sel_out;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [7:0] res_in = '0;
  logic       carry_in = 1'b0;
  logic [7:0] acc_out;
  logic       acc_carry, busy, err;
  logic [7:0] ops_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.WIDTH(8), .OPW(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .a_out(a_out), .b_out(b_out), .sel_out(sel_out),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .res_in(res_in),
    .carry_in(carry_in), .acc_out(acc_out), .acc_carry(acc_carry),
    .busy(busy), .err(err), .ops_count(ops_count)
  );

  typedef struct {
    logic [7:0] din; logic vin; logic ir; logic [7:0] res; logic cin;
    logic iv; logic rdy; logic bsy; logic er;
    logic [7:0] a; logic [7:0] b; logic [2:0] sel;
    logic [7:0] acc; logic ac; logic [7:0] ops;
  } vec_t;

  // Frame-level reference: tracks which operand bytes are still owed.
  logic [7:0] m_a, m_b, m_acc, m_ops;
  logic [2:0] m_sel;
  logic       m_carry, m_iss, m_need_a, m_need_b, m_err, m_e;
  int         m_idle;

  always @(posedge clk) begin
    if (rst) begin
      m_a = 0; m_b = 0; m_acc = 0; m_ops = 0; m_sel = 0; m_carry = 0;
      m_iss = 0; m_need_a = 0; m_need_b = 0; m_err = 0; m_idle = 0;
    end else begin
      m_e = 1'b0;
      if (m_iss) begin
        if (issue_ready) begin
          m_acc = res_in; m_carry = carry_in; m_ops = m_ops + 8'd1; m_iss = 0;
        end
      end else if (!m_need_a && !m_need_b) begin
        if (in_valid) begin
          if (in_data[7:5] != 3'd0) m_e = 1'b1;
          else begin
            m_sel = in_data[2:0];
            m_need_a = !in_data[3];
            m_need_b = !in_data[4];
            if (in_data[3]) begin
              m_a = m_acc;
              if (!m_need_b) m_b = 8'd0;
            end
            m_iss = !m_need_a && !m_need_b;
            m_idle = 0;
          end
        end
      end else begin
        if (in_valid) begin
          m_idle = 0;
          if (m_need_a) begin
            m_a = in_data; m_need_a = 0;
            if (!m_need_b) m_b = 8'd0;
          end else begin
            m_b = in_data; m_need_b = 0;
          end
          m_iss = !m_need_a && !m_need_b;
        end else begin
          m_idle = m_idle + 1;
          if (m_idle == TO) begin
            m_e = 1'b1; m_need_a = 0; m_need_b = 0; m_idle = 0;
          end
        end
      end
      m_err = m_e;
    end
  end

  function automatic vec_t model_exp();
    vec_t e;
    e = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
          8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00};
    e.iv = m_iss; e.rdy = !m_iss; e.bsy = m_iss | m_need_a | m_need_b;
    e.er = m_err; e.a = m_a; e.b = m_b; e.sel = m_sel;
    e.acc = m_acc; e.ac = m_carry; e.ops = m_ops;
    return e;
  endfunction

  task automatic check_outs(input string name, input vec_t e);
    logic bad;
    bad = (issue_valid !== e.iv) || (in_ready !== e.rdy) || (busy !== e.bsy) ||
          (err !== e.er) || (a_out !== e.a) || (b_out !== e.b) ||
          (acc_out !== e.acc) || (acc_carry !== e.ac) || (ops_count !== e.ops) ||
          (e.iv && (sel_out !== e.sel));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got iv=%b rdy=%b busy=%b err=%b a=%h b=%h sel=%0d acc=%h c=%b ops=%0d; want iv=%b rdy=%b busy=%b err=%b a=%h b=%h sel=%0d acc=%h c=%b ops=%0d",
               name, issue_valid, in_ready, busy, err, a_out, b_out, sel_out,
               acc_out, acc_carry, ops_count, e.iv, e.rdy, e.bsy, e.er, e.a,
               e.b, e.sel, e.acc, e.ac, e.ops);
    end
  endtask

  task automatic expect8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic ir,
                       input logic [7:0] r, input logic c);
    in_data = d; in_valid = v; issue_ready = ir; res_in = r; carry_in = c;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[13];
  vec_t zero_v;

  initial begin
    //           din    v     ir    res    c     iv    rdy   bsy   er    a      b      sel   acc    ac    ops
    tbl[0]  = '{8'h00,1'b1,1'b1,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h00,8'h00,3'd0,8'h00,1'b0,8'd0};
    tbl[1]  = '{8'h05,1'b1,1'b1,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0, 8'h00,8'h00,3'd0,8'h00,1'b0,8'd0};
    tbl[2]  = '{8'h03,1'b1,1'b1,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0, 8'h05,8'h00,3'd0,8'h00,1'b0,8'd0};
    tbl[3]  = '{8'h00,1'b0,1'b1,8'h08,1'b0, 1'b1,1'b0,1'b1,1'b0, 8'h05,8'h03,3'd0,8'h00,1'b0,8'd0};
    tbl[4]  = '{8'h08,1'b1,1'b1,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h05,8'h03,3'd0,8'h08,1'b0,8'd1};
    tbl[5]  = '{8'hFA,1'b1,1'b1,8'h00,1'b0, 1'b0,1'b1,1'b1,1'b0, 8'h08,8'h03,3'd0,8'h08,1'b0,8'd1};
    tbl[6]  = '{8'h00,1'b0,1'b1,8'h02,1'b1, 1'b1,1'b0,1'b1,1'b0, 8'h08,8'hFA,3'd0,8'h08,1'b0,8'd1};
    tbl[7]  = '{8'h1D,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h08,8'hFA,3'd0,8'h02,1'b1,8'd2};
    tbl[8]  = '{8'h55,1'b1,1'b0,8'h00,1'b0, 1'b1,1'b0,1'b1,1'b0, 8'h02,8'h00,3'd5,8'h02,1'b1,8'd2};
    tbl[9]  = '{8'h66,1'b1,1'b1,8'h04,1'b1, 1'b1,1'b0,1'b1,1'b0, 8'h02,8'h00,3'd5,8'h02,1'b1,8'd2};
    tbl[10] = '{8'h20,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h02,8'h00,3'd0,8'h04,1'b1,8'd3};
    tbl[11] = '{8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b1, 8'h02,8'h00,3'd0,8'h04,1'b1,8'd3};
    tbl[12] = '{8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h02,8'h00,3'd0,8'h04,1'b1,8'd3};
    zero_v  = '{8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,1'b0,1'b0, 8'h00,8'h00,3'd0,8'h00,1'b0,8'd0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].din, tbl[i].vin, tbl[i].ir, tbl[i].res, tbl[i].cin);
      check_outs($sformatf("dir%0d", i), tbl[i]);
      tick();
    end

    // ACC_A|UNARY AND held in ISSUE for 10 cycles, handshake on the 11th.
    drive(8'h1A, 1'b1, 1'b0, 8'h00, 1'b0);
    check_outs("hold_cmd", model_exp());
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(8'($urandom), 1'(k % 2), 1'b0, 8'($urandom), 1'b0);
      check_outs("hold", model_exp());
      expect8("hold_iv", 8'(issue_valid), 8'd1);
      expect8("hold_rdy", 8'(in_ready), 8'd0);
      expect8("hold_a", a_out, 8'h04);
      expect8("hold_sel", 8'(sel_out), 8'd2);
      tick();
    end
    drive(8'h00, 1'b0, 1'b1, 8'h3C, 1'b0);
    check_outs("hold_hs", model_exp());
    tick();
    check_outs("hold_done", model_exp());
    expect8("hold_ops", ops_count, 8'd4);
    expect8("hold_acc", acc_out, 8'h3C);

    // Timeout: command needing A and B, then silence.
    drive(8'h02, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int j = 1; j <= TO + 2; j++) begin
      drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      check_outs("timeout", model_exp());
      expect8("to_err", 8'(err), 8'(j == TO + 1));
      expect8("to_busy", 8'(busy), 8'(j <= TO));
      tick();
    end
    expect8("to_ops", ops_count, 8'd4);

    // ops_count wrap after 256 issues.
    do_reset();
    for (int n = 1; n <= 256; n++) begin
      drive(8'h18, 1'b1, 1'b0, 8'h00, 1'b0);
      check_outs("wrap_cmd", model_exp());
      tick();
      drive(8'h00, 1'b0, 1'b1, 8'h77, 1'b1);
      tick();
      if (n == 255) expect8("wrap_255", ops_count, 8'd255);
    end
    expect8("wrap_0", ops_count, 8'd0);
    expect8("wrap_acc", acc_out, 8'h77);

    // Reset while waiting in GET_B.
    drive(8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    expect8("getb_busy", 8'(busy), 8'd1);
    rst = 1'b1;
    drive(8'h22, 1'b1, 1'b1, 8'h55, 1'b1);
    tick();
    rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check_outs("rst_getb", zero_v);
    expect8("rst_sel", 8'(sel_out), 8'd0);

    // Randomized traffic with varying byte density.
    for (int seg = 0; seg < 16; seg++) begin
      int p;
      case (seg % 3)
        0: p = 70;
        1: p = 30;
        default: p = 4;
      endcase
      for (int c = 0; c < 250; c++) begin
        logic [7:0] d;
        if (!m_iss && !m_need_a && !m_need_b) begin
          if ($urandom_range(0, 9) == 0) d = 8'($urandom) | 8'h20;
          else d = {3'b000, 5'($urandom)};
        end else begin
          d = 8'($urandom);
        end
        drive(d, 1'($urandom_range(0, 99) < p), 1'($urandom), 8'($urandom), 1'($urandom));
        check_outs("rand", model_exp());
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
